multu_hilo_unit: RTL and testbench
==================================

MULTU_HILO_UNIT -- requirements
Module: multu_hilo_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; HI and LO are each WIDTH bits.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset, sampled on rising clk.
REQ-004 SHALL have port start, input, 1: multu request, driven from the decoder's MULTU multiply-write control.
REQ-005 SHALL have port a, input, WIDTH: rs operand, unsigned.
REQ-006 SHALL have port b, input, WIDTH: rt operand, unsigned.
REQ-007 SHALL have port rd_req, input, 1: mfhi/mflo read request.
REQ-008 SHALL have port hi_sel, input, 1: read select; 1=HI (mfhi), 0=LO (mflo).
REQ-009 SHALL have port hilo_out, output, WIDTH: selected HI or LO register contents.
REQ-010 SHALL have port busy, output, 1: multiply in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when HI/LO are updated.
REQ-012 SHALL have port stall, output, 1: pipeline hold request to the hazard logic.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1 at an edge SHALL latch a and b, clear the accumulator and the iteration counter, and go to RUN.
REQ-015 IDLE or DONE with start=0 at an edge SHALL go to IDLE.
REQ-016 RUN SHALL perform one shift-add iteration per cycle, WIDTH iterations total, on a 2*WIDTH-bit accumulator with no truncation.
REQ-017 The iteration counter SHALL be clog2(WIDTH)+1 bits wide, so the last-iteration compare does not wrap.
REQ-018 On the edge completing iteration WIDTH, HI SHALL take product[2*WIDTH-1:WIDTH], LO SHALL take product[WIDTH-1:0], and the FSM SHALL go to DONE.
REQ-019 Latency: start sampled at edge k gives new HI/LO visible after edge k+WIDTH, and done=1 for exactly the cycle between edges k+WIDTH and k+WIDTH+1.
REQ-020 busy SHALL be 1 exactly while the state is RUN.
REQ-021 done SHALL be 1 exactly while the state is DONE.
REQ-022 HI/LO SHALL change only at the completion edge (REQ-018) or on reset.
REQ-023 Back-to-back: start=1 during DONE SHALL begin a new multiply with no idle cycle.
REQ-024 start=1 during RUN SHALL be ignored; it SHALL NOT restart the multiply or relatch operands.
REQ-025 stall SHALL be combinational: stall = busy & (start | rd_req).
REQ-026 The CPU holds start and rd_req until stall=0.
REQ-027 hilo_out SHALL be combinational: hi_sel ? HI : LO.
REQ-028 While busy, hilo_out SHALL show the previous HI/LO values.
REQ-029 In DONE, hilo_out SHALL already show the new result, so an mfhi/mflo in the done cycle returns the new result without stall.
REQ-030 a, b and the operand inputs SHALL be don't-care outside the start-accept edge.

Reset
REQ-031 rst=1 at an edge SHALL set state=IDLE and HI=0, LO=0, accumulator=0, counter=0.
REQ-032 After that reset edge, outputs SHALL be busy=0, done=0, stall=0, hilo_out=0.
REQ-033 Reset SHALL take priority over start at the same edge.
REQ-034 Reset mid-RUN SHALL abandon the multiply: HI/LO=0, no done pulse.

Verification
REQ-035 Basic multiply: reset; start with a=3, b=5 for 1 cycle -> busy=1 for 32 cycles, then done=1 for 1 cycle; hi_sel=0 gives 0x0000000F; hi_sel=1 gives 0x00000000.
REQ-036 Max operands: a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; zero operand (a=0, b=0x12345678) -> HI=LO=0.
REQ-037 Read hazard: rd_req=1 during RUN -> stall=1 every RUN cycle and hilo_out holds the previous result; in the done cycle stall=0 and hilo_out is the new value.
REQ-038 Start while busy: a=2, b=7 in flight; start with a=9, b=9 at cycle 10 -> stall=1, operands ignored, result LO=14.
REQ-039 Back-to-back: start held through done with a=0x10000, b=0x10000 -> second RUN begins the cycle after done; HI=0x00000001, LO=0x00000000.
REQ-040 Reset mid-op: rst at RUN cycle 16 -> next cycle busy=0, done=0, hilo_out=0; no later done pulse.

Source files
------------

// File: rtl/multu_hilo_unit.sv
// Unsigned sequential multiplier writing the HI/LO register pair (MIPS multu).
// Latency: WIDTH cycles from the start-accept edge to HI/LO update; done pulses for one cycle after that.
// Backpressure: stall is raised while busy if a new multiply or an mfhi/mflo read is requested.
module multu_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_req,
   input  logic             hi_sel,
   output logic [WIDTH-1:0] hilo_out,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   // One extra counter bit so the count can reach WIDTH without wrapping.
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 accept;
   logic                 last_iter;
   logic [2*WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   acc_sum;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_inc;

   // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_sum   = mplier[0] ? (acc + mcand) : acc;
      cnt_inc   = cnt + CW'(1);
      last_iter = (cnt_inc == CW'(WIDTH));
   end

   // State register; reset wins over any request at the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and status outputs; start is only honoured from IDLE or DONE.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last_iter) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Iteration datapath: latch operands on accept, then shift one multiplier bit per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (accept) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (busy) begin
         acc    <= acc_sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt_inc;
      end
   end

   // HI/LO only move on the final iteration, so reads during RUN see the previous result.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (busy && last_iter) begin
         hi <= acc_sum[2*WIDTH-1:WIDTH];
         lo <= acc_sum[WIDTH-1:0];
      end
   end

   assign stall    = busy & (start | rd_req);
   assign hilo_out = hi_sel ? hi : lo;

endmodule

// File: tb/tb_multu_hilo_unit.sv
module tb_multu_hilo_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         rd_req;
   logic         hi_sel;
   logic [W-1:0] hilo_out;
   logic         busy;
   logic         done;
   logic         stall;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // Reference model: cycles left in the multiply, pending product, visible HI/LO.
   int           m_cnt  = 0;
   bit           m_done = 1'b0;
   logic [63:0]  m_prod = '0;
   logic [W-1:0] m_hi   = '0;
   logic [W-1:0] m_lo   = '0;

   multu_hilo_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .rd_req   (rd_req),
      .hi_sel   (hi_sel),
      .hilo_out (hilo_out),
      .busy     (busy),
      .done     (done),
      .stall    (stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: a multiply takes W cycles, then the result is visible and done lasts one cycle.
   always @(posedge clk) begin
      if (rst) begin
         m_cnt  = 0;
         m_done = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
      end else if (m_cnt != 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_hi   = m_prod[63:32];
            m_lo   = m_prod[31:0];
            m_done = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            m_prod = {32'd0, a} * {32'd0, b};
            m_cnt  = W;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, (m_cnt != 0));
         check("done", done, m_done);
         check("stall", stall, (m_cnt != 0) & (start | rd_req));
         check("hilo_out", hilo_out, hi_sel ? m_hi : m_lo);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 200) begin
         step();
         n++;
      end
      check("wait_done", done, 1'b1);
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1;
      a     = x;
      b     = y;
      step();
      start = 1'b0;
      wait_done();
   endtask

   initial begin
      int n;
      bit seen;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; rd_req = 1'b0; hi_sel = 1'b0;
      step();
      step();
      chk_en = 1'b1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_hilo", hilo_out, 32'h0);
      rst = 1'b0;
      step();

      // 3 * 5: exactly W busy cycles, then one done cycle.
      start = 1'b1; a = 32'd3; b = 32'd5;
      step();
      start = 1'b0;
      n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      check("busy_cycles", n, 32);
      check("done_3x5", done, 1'b1);
      hi_sel = 1'b0; #1;
      check("lo_3x5", hilo_out, 32'h0000000F);
      check("model_lo_3x5", m_lo, 32'h0000000F);
      hi_sel = 1'b1; #1;
      check("hi_3x5", hilo_out, 32'h00000000);
      step();
      check("done_one_cycle", done, 1'b0);

      // Zero operand, then max operands.
      run_op(32'h0, 32'h12345678);
      hi_sel = 1'b1; #1; check("hi_zero", hilo_out, 32'h0);
      hi_sel = 1'b0; #1; check("lo_zero", hilo_out, 32'h0);
      step();
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF);
      hi_sel = 1'b1; #1; check("hi_max", hilo_out, 32'hFFFFFFFE);
      check("model_hi_max", m_hi, 32'hFFFFFFFE);
      hi_sel = 1'b0; #1; check("lo_max", hilo_out, 32'h00000001);
      step();

      // Read hazard: mfhi held through RUN sees the old HI and stalls.
      hi_sel = 1'b1; rd_req = 1'b1;
      start = 1'b1; a = 32'd2; b = 32'd3;
      step();
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         check("hz_stall", stall, 1'b1);
         check("hz_old_hi", hilo_out, 32'hFFFFFFFE);
         step();
      end
      check("hz_done", done, 1'b1);
      check("hz_done_stall", stall, 1'b0);
      check("hz_new_hi", hilo_out, 32'h0);
      hi_sel = 1'b0; #1;
      check("hz_new_lo", hilo_out, 32'd6);
      rd_req = 1'b0;
      step();

      // Start while busy is ignored.
      start = 1'b1; a = 32'd2; b = 32'd7;
      step();
      start = 1'b0;
      repeat (9) step();
      start = 1'b1; a = 32'd9; b = 32'd9; #1;
      check("busy_start_stall", stall, 1'b1);
      wait_done();
      hi_sel = 1'b0; #1;
      check("busy_start_lo", hilo_out, 32'd14);
      start = 1'b0;
      step();

      // Back-to-back: start held through done.
      start = 1'b1; a = 32'h10000; b = 32'h10000;
      wait_done();
      hi_sel = 1'b1; #1; check("b2b_hi", hilo_out, 32'h1);
      hi_sel = 1'b0; #1; check("b2b_lo", hilo_out, 32'h0);
      step();
      check("b2b_rerun", busy, 1'b1);
      start = 1'b0;
      wait_done();
      step();

      // Reset in the middle of RUN abandons the multiply.
      start = 1'b1; a = 32'd5; b = 32'd5;
      step();
      start = 1'b0;
      repeat (16) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      hi_sel = 1'b1; #1; check("mid_rst_hi", hilo_out, 32'h0);
      hi_sel = 1'b0; #1; check("mid_rst_lo", hilo_out, 32'h0);
      seen = 1'b0;
      repeat (40) begin
         step();
         seen |= done;
      end
      check("mid_rst_no_done", seen, 1'b0);

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst    = ($urandom_range(0, 299) == 0);
         start  = ($urandom_range(0, 2) == 0);
         rd_req = $urandom_range(0, 1);
         hi_sel = $urandom_range(0, 1);
         case ($urandom_range(0, 5))
            0:       a = '0;
            1:       a = '1;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = '1;
            default: b = $urandom;
         endcase
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
